// File: rtl/bpf16_out_requant_if.sv
// ---------------------------------------------------------------------------
// bpf16_out_requant_if
// Stream bundle for the BPF output requantizer. Carries both sides of the
// block: the Q2.14 sample stream coming from the filter (s_*) and the
// requantized Q1.11 stream going downstream (m_*).
//
// Modports:
//   slave  - the requantizer's view: sinks s_*, sources m_*
//   master - the surrounding logic's view: sources s_* and m_ready,
//            observes s_ready and m_*
// ---------------------------------------------------------------------------
interface bpf16_out_requant_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 12
);
  logic signed [IN_WIDTH-1:0]  s_data;
  logic                        s_valid;
  logic                        s_ready;
  logic signed [OUT_WIDTH-1:0] m_data;
  logic                        m_valid;
  logic                        m_ready;

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/bpf16_out_requant.sv
// ---------------------------------------------------------------------------
// bpf16_out_requant
// Receive-side companion of the 16-tap BPF core. Buffers incoming Q2.14
// samples in a small FIFO, keeps one sample out of every DECIM, rounds
// (half-up) and saturates each kept sample to Q1.11 and presents it on a
// valid/ready output. Counts kept samples that saturated (sticky at 0xFFFF).
//
// Ports:
//   clk       - clock, rising edge
//   rstn      - synchronous active-low reset
//   bus       - stream bundle (slave modport): s_data/s_valid/s_ready in,
//               m_data/m_valid/m_ready out
//   sat_count - number of kept samples that were clamped
// ---------------------------------------------------------------------------
module bpf16_out_requant #(
  parameter int IN_WIDTH   = 16,
  parameter int IN_FRAC    = 14,
  parameter int OUT_WIDTH  = 12,
  parameter int OUT_FRAC   = 11,
  parameter int DECIM      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  bpf16_out_requant_if.slave   bus,
  output logic [15:0]          sat_count
);

  localparam int SH    = IN_FRAC - OUT_FRAC;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int EXT_W = IN_WIDTH + 1;

  typedef struct packed {
    logic                        sat;
    logic signed [OUT_WIDTH-1:0] val;
  } rq_t;

  // Round half-up then clamp. One guard bit keeps the rounding add from
  // wrapping on the most positive input.
  function automatic rq_t requant(input logic signed [IN_WIDTH-1:0] x);
    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] shr;
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    rq_t r;
    hi  = EXT_W'((1 << (OUT_WIDTH-1)) - 1);
    lo  = -hi - EXT_W'(1);
    ext = {x[IN_WIDTH-1], x};
    shr = (ext + EXT_W'(1 << (SH-1))) >>> SH;
    if (shr > hi) begin
      r.sat = 1'b1;
      r.val = hi[OUT_WIDTH-1:0];
    end else if (shr < lo) begin
      r.sat = 1'b1;
      r.val = lo[OUT_WIDTH-1:0];
    end else begin
      r.sat = 1'b0;
      r.val = shr[OUT_WIDTH-1:0];
    end
    return r;
  endfunction

  logic signed [IN_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [PH_W-1:0]             phase_q, phase_d;
  logic                        s_ready_q, s_ready_d;
  logic                        m_valid_q, m_valid_d;
  logic signed [OUT_WIDTH-1:0] m_data_q, m_data_d;
  logic [15:0]                 sat_q, sat_d;

  logic push;
  logic pop;
  logic keep_pop;
  rq_t  rq;

  always_comb begin
    push     = bus.s_valid && s_ready_q;
    // Discard pops never wait on the output register; only keep pops do.
    pop      = (count_q != '0) &&
               ((phase_q != '0) || !m_valid_q || bus.m_ready);
    keep_pop = pop && (phase_q == '0);
    rq       = requant(mem_q[rd_ptr_q]);

    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    s_ready_d = (count_d != CNT_W'(FIFO_DEPTH));

    phase_d = phase_q;
    if (pop) begin
      phase_d = (phase_q == PH_W'(DECIM-1)) ? '0 : phase_q + 1'b1;
    end

    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (keep_pop) begin
      m_valid_d = 1'b1;
      m_data_d  = rq.val;
    end else if (m_valid_q && bus.m_ready) begin
      m_valid_d = 1'b0;
    end

    sat_d = sat_q;
    if (keep_pop && rq.sat && (sat_q != 16'hFFFF)) begin
      sat_d = sat_q + 16'd1;
    end
  end

  // Sample storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      phase_q   <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      sat_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      phase_q   <= phase_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      sat_q     <= sat_d;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign sat_count   = sat_q;

endmodule

// File: tb/tb_bpf16_out_requant.sv
// ---------------------------------------------------------------------------
// tb_bpf16_out_requant
// Self-checking bench for bpf16_out_requant. Three instances share clk/rstn
// and differ only in DECIM (1, 2, 3). Inputs are driven 1 time unit after
// the rising edge; outputs and handshakes are observed on the falling edge.
// ---------------------------------------------------------------------------
module tb_bpf16_out_requant;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bpf16_out_requant_if #(.IN_WIDTH(16), .OUT_WIDTH(12)) i1 ();
  bpf16_out_requant_if #(.IN_WIDTH(16), .OUT_WIDTH(12)) i2 ();
  bpf16_out_requant_if #(.IN_WIDTH(16), .OUT_WIDTH(12)) i3 ();
  logic [15:0] sat1, sat2, sat3;

  bpf16_out_requant #(.IN_WIDTH(16), .IN_FRAC(14), .OUT_WIDTH(12),
                      .OUT_FRAC(11), .DECIM(1), .FIFO_DEPTH(4))
    u1 (.clk(clk), .rstn(rstn), .bus(i1.slave), .sat_count(sat1));
  bpf16_out_requant #(.IN_WIDTH(16), .IN_FRAC(14), .OUT_WIDTH(12),
                      .OUT_FRAC(11), .DECIM(2), .FIFO_DEPTH(4))
    u2 (.clk(clk), .rstn(rstn), .bus(i2.slave), .sat_count(sat2));
  bpf16_out_requant #(.IN_WIDTH(16), .IN_FRAC(14), .OUT_WIDTH(12),
                      .OUT_FRAC(11), .DECIM(3), .FIFO_DEPTH(4))
    u3 (.clk(clk), .rstn(rstn), .bus(i3.slave), .sat_count(sat3));

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: value/8 rounded half toward +inf, without clamping.
  function automatic int rq_raw(input int x);
    int t;
    t = x + 4;
    if (t >= 0) return t / 8;
    return -((-t + 7) / 8);
  endfunction

  function automatic int rq_model(input int x);
    int q;
    q = rq_raw(x);
    if (q > 2047)  q = 2047;
    if (q < -2048) q = -2048;
    return q;
  endfunction

  function automatic bit sat_model(input int x);
    return (rq_raw(x) > 2047) || (rq_raw(x) < -2048);
  endfunction

  // Handshake monitors
  int in_q1[$], out_q1[$], in_q2[$], out_q2[$], in_q3[$], out_q3[$];
  always @(negedge clk) begin
    if (rstn) begin
      if (i1.s_valid && i1.s_ready) in_q1.push_back(int'(i1.s_data));
      if (i1.m_valid && i1.m_ready) out_q1.push_back(int'(i1.m_data));
      if (i2.s_valid && i2.s_ready) in_q2.push_back(int'(i2.s_data));
      if (i2.m_valid && i2.m_ready) out_q2.push_back(int'(i2.m_data));
      if (i3.s_valid && i3.s_ready) in_q3.push_back(int'(i3.s_data));
      if (i3.m_valid && i3.m_ready) out_q3.push_back(int'(i3.m_data));
    end
  end

  // Output of u3 must hold while stalled.
  logic              st3_prev = 1'b0;
  logic signed [11:0] st3_data = '0;
  always @(negedge clk) begin
    if (rstn && st3_prev)
      check("stall_hold", longint'({i3.m_valid, i3.m_data}), longint'({1'b1, st3_data}));
    st3_prev <= rstn && i3.m_valid && !i3.m_ready;
    st3_data <= i3.m_data;
  end

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    i1.s_valid = 1'b0; i1.m_ready = 1'b0;
    i2.s_valid = 1'b0; i2.m_ready = 1'b0;
    i3.s_valid = 1'b0; i3.m_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic send1(input logic [15:0] d);
    int b;
    @(posedge clk);
    #1;
    i1.s_valid = 1'b1;
    i1.s_data  = d;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!i1.s_ready && b < 20);
    if (!i1.s_ready) check("send1_timeout", 0, 1);
    @(posedge clk);
    #1;
    i1.s_valid = 1'b0;
  endtask

  task automatic get1(output int d);
    int b;
    d = 99999;
    b = 0;
    while (b < 20) begin
      @(negedge clk);
      if (i1.m_valid) begin
        d = int'(i1.m_data);
        break;
      end
      b++;
    end
    if (b >= 20) check("get1_timeout", 0, 1);
  endtask

  task automatic push_u2(input int vals[$], output int cyc);
    int k;
    k   = 0;
    cyc = 0;
    @(posedge clk);
    #1;
    i2.s_valid = 1'b1;
    i2.s_data  = 16'(vals[0]);
    while (k < vals.size() && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (i2.s_ready) k++;
      @(posedge clk);
      #1;
      if (k < vals.size()) i2.s_data = 16'(vals[k]);
    end
    i2.s_valid = 1'b0;
    if (k < vals.size()) check("push_u2_timeout", k, vals.size());
  endtask

  typedef struct {
    logic [15:0] din;
    int          exp_q;
  } vec_t;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int   got;
    int   cyc;
    int   vals[$];
    int   acc[$];
    int   idx;
    int   exp_sat;
    int   exp_out[$];

    i1.s_data = '0; i1.s_valid = 1'b0; i1.m_ready = 1'b0;
    i2.s_data = '0; i2.s_valid = 1'b0; i2.m_ready = 1'b0;
    i3.s_data = '0; i3.s_valid = 1'b0; i3.m_ready = 1'b0;

    tbl[0] = '{16'h4000,  2047};
    tbl[1] = '{16'hC000, -2048};
    tbl[2] = '{16'h000C,     2};
    tbl[3] = '{16'h000B,     1};
    tbl[4] = '{16'hFFF4,    -1};
    tbl[5] = '{16'hFFF3,    -2};
    tbl[6] = '{16'h7FFF,  2047};
    tbl[7] = '{16'h8000, -2048};

    // ---- reset state ----
    do_reset(3);
    @(negedge clk);
    check("rst_s_ready", i1.s_ready, 0);
    check("rst_m_valid", i1.m_valid, 0);
    check("rst_m_data",  i1.m_data, 0);
    check("rst_sat",     sat1, 0);
    check("rst_s_ready_u3", i3.s_ready, 0);
    @(negedge clk);
    check("rst_s_ready_rise", i1.s_ready, 1);

    // ---- requant table, DECIM=1 ----
    i1.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send1(tbl[i].din);
      get1(got);
      check($sformatf("requant[%0d]", i), got, tbl[i].exp_q);
    end
    check("requant_sat_count", sat1, 3);

    // ---- latency ----
    do_reset(2);
    i1.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i1.s_valid = 1'b1;
    i1.s_data  = 16'(8 * 5);
    @(negedge clk);
    check("lat_accept", i1.s_ready, 1);
    @(posedge clk);
    #1;
    i1.s_valid = 1'b0;
    @(negedge clk);
    check("lat_mvalid_n1", i1.m_valid, 0);
    @(negedge clk);
    check("lat_mvalid_n2", i1.m_valid, 1);
    check("lat_mdata", i1.m_data, 5);
    @(negedge clk);
    check("lat_mvalid_n3", i1.m_valid, 0);

    // ---- decimation, DECIM=2 ----
    do_reset(2);
    i2.m_ready = 1'b1;
    @(posedge clk);
    in_q2.delete();
    out_q2.delete();
    vals.delete();
    for (int k = 1; k <= 10; k++) vals.push_back(8 * k);
    push_u2(vals, cyc);
    check("dec_in_cycles", cyc, 10);
    repeat (8) @(negedge clk);
    check("dec_in_count", in_q2.size(), 10);
    check("dec_out_count", out_q2.size(), 5);
    for (int i = 0; i < 5 && i < out_q2.size(); i++)
      check($sformatf("dec_out[%0d]", i), out_q2[i], 2 * i + 1);

    // ---- backpressure / full, DECIM=1 ----
    do_reset(2);
    out_q1.delete();
    acc.delete();
    idx = 0;
    i1.s_valid = 1'b1;
    i1.s_data  = 16'(8 * 100);
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (i1.s_ready) begin
        acc.push_back(8 * (100 + idx));
        idx++;
      end
      @(posedge clk);
      #1;
      i1.s_data = 16'(8 * (100 + idx));
    end
    i1.s_valid = 1'b0;
    check("bp_accepted", acc.size(), 5);
    @(negedge clk);
    check("bp_s_ready_low", i1.s_ready, 0);
    check("bp_m_valid", i1.m_valid, 1);
    check("bp_m_data_head", i1.m_data, 100);
    @(posedge clk);
    #1;
    i1.m_ready = 1'b1;
    @(negedge clk);
    check("bp_s_ready_pre", i1.s_ready, 0);
    @(negedge clk);
    check("bp_s_ready_reopen", i1.s_ready, 1);
    repeat (10) @(negedge clk);
    check("bp_out_count", out_q1.size(), acc.size());
    for (int i = 0; i < acc.size() && i < out_q1.size(); i++)
      check($sformatf("bp_out[%0d]", i), out_q1[i], rq_model(acc[i]));

    // ---- mid-stream reset, DECIM=2 ----
    do_reset(2);
    vals.delete();
    vals.push_back(32'h7FFF);
    for (int k = 0; k < 4; k++) vals.push_back(8 * (30 + k));
    push_u2(vals, cyc);
    @(negedge clk);
    check("mr_pre_m_valid", i2.m_valid, 1);
    check("mr_pre_m_data", i2.m_data, 2047);
    check("mr_pre_sat", sat2, 1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    i2.s_valid = 1'b1;
    i2.s_data  = 16'h7FFF;
    i2.m_ready = 1'b1;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    i2.s_valid = 1'b0;
    i2.m_ready = 1'b0;
    @(negedge clk);
    check("mr_m_valid", i2.m_valid, 0);
    check("mr_s_ready", i2.s_ready, 0);
    check("mr_sat", sat2, 0);
    @(posedge clk);
    #1;
    out_q2.delete();
    i2.m_ready = 1'b1;
    vals.delete();
    vals.push_back(8 * 21);
    vals.push_back(8 * 22);
    vals.push_back(8 * 23);
    push_u2(vals, cyc);
    repeat (8) @(negedge clk);
    check("mr_post_count", out_q2.size(), 2);
    if (out_q2.size() >= 2) begin
      check("mr_post_first", out_q2[0], 21);
      check("mr_post_second", out_q2[1], 23);
    end

    // ---- random valid/ready, DECIM=3 ----
    do_reset(2);
    @(posedge clk);
    in_q3.delete();
    out_q3.delete();
    cyc = 0;
    while (in_q3.size() < 2000 && cyc < 20000) begin
      #1;
      i3.s_valid = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 9) < 4) i3.s_data = 16'($urandom());
      else i3.s_data = 16'(int'($urandom_range(0, 8191)) - 4096);
      i3.m_ready = ($urandom_range(0, 99) < 55);
      @(posedge clk);
      cyc++;
    end
    #1;
    i3.s_valid = 1'b0;
    i3.m_ready = 1'b1;
    repeat (30) @(negedge clk);
    check("rand_enough_inputs", (in_q3.size() >= 2000) ? 1 : 0, 1);
    exp_out.delete();
    exp_sat = 0;
    for (int i = 0; i < in_q3.size(); i += 3) begin
      exp_out.push_back(rq_model(in_q3[i]));
      if (sat_model(in_q3[i])) exp_sat++;
    end
    check("rand_out_count", out_q3.size(), exp_out.size());
    for (int i = 0; i < exp_out.size() && i < out_q3.size(); i++)
      check($sformatf("rand_out[%0d]", i), out_q3[i], exp_out[i]);
    check("rand_sat_count", sat3, exp_sat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
